vga_fb_scheduler: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM between two users:
//   - VGA scanout reads (hard priority)
//   - one pixel writer (valid/ready handshake, one-entry buffer)

---
 rtl/vga_fb_scheduler_if.sv | 25 ++
 rtl/vga_fb_scheduler.sv | 123 ++++++++++++
 tb/tb_vga_fb_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_scheduler_if.sv
// Writer handshake and framebuffer RAM bus shared by the scheduler.
// The scheduler takes the slave side; writer and RAM sit on the master side.
interface vga_fb_scheduler_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fb_scheduler.sv
// Arbitrates one single-port framebuffer RAM between VGA scanout
// reads (hard priority) and a one-entry buffered pixel writer.
module vga_fb_scheduler #(
  parameter int H_PIX    = 640,
  parameter int V_PIX    = 480,
  parameter int SCALE_SH = 2,
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              isdisplayed,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  vga_fb_scheduler_if.slave bus,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              wr_oob
);

  localparam int FB_W     = H_PIX >> SCALE_SH;
  localparam int FB_H     = V_PIX >> SCALE_SH;
  localparam int FB_WORDS = FB_W * FB_H;
  localparam logic [9:0] SUB_MASK = 10'((1 << SCALE_SH) - 1);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  logic              ds;
  logic [ADDR_W-1:0] ds_addr;
  logic              issue;
  logic              accept;
  logic              in_range;

  logic              ds_d1;
  logic              disp_d1;
  logic [DATA_W-1:0] hold;

  // The first clock of each replicated pixel group belongs to scanout.
  assign ds = isdisplayed && ((x & SUB_MASK) == 10'd0);

  assign ds_addr = ADDR_W'(y >> SCALE_SH) * ADDR_W'(FB_W)
                 + ADDR_W'(x >> SCALE_SH);

  assign issue    = (state == FULL) && !ds;
  assign in_range = 32'(bus.wr_addr) < 32'(FB_WORDS);

  // Ready whenever the buffer drains this cycle or is already empty.
  assign bus.wr_ready = (state == EMPTY) || !ds;
  assign accept       = bus.wr_valid && bus.wr_ready;

  // RAM port mux: scanout first, then the buffered write, else idle.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      ds: begin
        bus.mem_addr = ds_addr;
      end
      issue: begin
        bus.mem_addr  = buf_addr;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = buf_data;
      end
      default: begin
      end
    endcase
  end

  // Write buffer: capture accepted in-range writes, drain on free slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      buf_addr <= '0;
      buf_data <= '0;
      wr_oob   <= 1'b0;
    end else begin
      if (accept && in_range) begin
        state    <= FULL;
        buf_addr <= bus.wr_addr;
        buf_data <= bus.wr_data;
      end else if (issue) begin
        state <= EMPTY;
      end
      if (accept && !in_range) begin
        wr_oob <= 1'b1;
      end
    end
  end

  // Scanout: read data of a scanout slot lands next cycle, pixel after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_d1     <= 1'b0;
      disp_d1   <= 1'b0;
      hold      <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      ds_d1     <= ds;
      disp_d1   <= isdisplayed;
      pix_valid <= disp_d1;
      if (ds_d1) begin
        hold <= bus.mem_rdata;
      end
      if (!disp_d1) begin
        pix_data <= '0;
      end else if (ds_d1) begin
        pix_data <= bus.mem_rdata;
      end else begin
        pix_data <= hold;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Self-checking bench for vga_fb_scheduler with a RAM model and a
// behavioural framebuffer/writer reference model.
module tb_vga_fb_scheduler;

  localparam int FB_W     = 160;
  localparam int FB_WORDS = 19200;
  localparam int PRE_N    = 1280;

  logic        clk = 1'b0;
  logic        reset;
  logic        isdisplayed;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        wr_oob;

  vga_fb_scheduler_if #(.ADDR_W(15), .DATA_W(12)) bus_if ();

  vga_fb_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .isdisplayed(isdisplayed),
    .x          (x),
    .y          (y),
    .bus        (bus_if),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .wr_oob     (wr_oob)
  );

  always #5 clk = ~clk;

  logic [11:0] ram [0:32767];
  logic        pre_en;
  logic [14:0] pre_addr;
  logic [11:0] pre_data;

  // Synchronous single-port RAM with a preload port for the bench.
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (bus_if.mem_we) ram[bus_if.mem_addr] <= bus_if.mem_wdata;
    bus_if.mem_rdata <= ram[bus_if.mem_addr];
  end

  typedef struct {
    logic [14:0] a;
    logic [11:0] d;
  } wr_t;

  logic [11:0] gold [0:32767];
  wr_t         q[$];
  bit          hv[$];
  logic [11:0] hd[$];
  bit          oob_m;
  logic [11:0] grp_val;
  int          tests = 0;
  int          failed = 0;
  int          we_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hv.delete();
    hd.delete();
    hv.push_back(1'b0);
    hv.push_back(1'b0);
    hd.push_back(12'h0);
    hd.push_back(12'h0);
    oob_m   = 1'b0;
    grp_val = 12'h0;
  endtask

  task automatic idle_inputs();
    isdisplayed     = 1'b0;
    x               = 10'd0;
    y               = 10'd0;
    bus_if.wr_valid = 1'b0;
    bus_if.wr_addr  = 15'd0;
    bus_if.wr_data  = 12'd0;
  endtask

  // One clock: drive at negedge, check, then advance the reference model.
  task automatic cyc(input bit disp, input int xi, input int yi,
                     input bit wv, input int wa, input logic [11:0] wd,
                     output bit acc);
    bit ds;
    bit exp_we;
    bit exp_rdy;
    int da;
    @(negedge clk);
    isdisplayed     = disp;
    x               = 10'(xi);
    y               = 10'(yi);
    bus_if.wr_valid = wv;
    bus_if.wr_addr  = 15'(wa);
    bus_if.wr_data  = wd;
    #1;
    ds      = disp && (xi % 4 == 0);
    da      = (yi / 4) * FB_W + xi / 4;
    exp_we  = !ds && (q.size() > 0);
    exp_rdy = !ds || (q.size() == 0);
    check("wr_oob", 32'(wr_oob), 32'(oob_m));
    check("pix_valid", 32'(pix_valid), 32'(hv[0]));
    check("pix_data", 32'(pix_data), 32'(hd[0]));
    void'(hv.pop_front());
    void'(hd.pop_front());
    check("wr_ready", 32'(bus_if.wr_ready), 32'(exp_rdy));
    check("mem_we", 32'(bus_if.mem_we), 32'(exp_we));
    if (ds) begin
      check("ds_addr", 32'(bus_if.mem_addr), 32'(da));
    end else if (exp_we) begin
      check("wr_addr_out", 32'(bus_if.mem_addr), 32'(q[0].a));
      check("wr_data_out", 32'(bus_if.mem_wdata), 32'(q[0].d));
    end else begin
      check("idle_addr", 32'(bus_if.mem_addr), 32'd0);
      check("idle_wdata", 32'(bus_if.mem_wdata), 32'd0);
    end
    if (bus_if.mem_we) we_cnt++;
    if (ds) grp_val = gold[da];
    hv.push_back(disp);
    hd.push_back(disp ? grp_val : 12'h0);
    if (exp_we) begin
      gold[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    acc = wv && exp_rdy;
    if (acc) begin
      if (wa >= FB_WORDS) oob_m = 1'b1;
      else q.push_back('{a: 15'(wa), d: wd});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit          acc;
    bit          cur_v;
    int          cur_a;
    logic [11:0] cur_d;
    int          ys;
    int          xs;
    int          len;
    int          addrs[$];

    reset  = 1'b1;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    idle_inputs();
    model_reset();
    for (int i = 0; i < 32768; i++) gold[i] = 12'h0;
    for (int i = 0; i < PRE_N; i++) gold[i] = 12'($urandom);
    gold[161] = 12'hABC;
    for (int i = 0; i < PRE_N; i++) begin
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = 15'(i);
      pre_data = gold[i];
    end
    @(negedge clk);
    pre_en = 1'b0;
    #1;
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_wr_ready", 32'(bus_if.wr_ready), 32'd1);
    check("rst_mem_we", 32'(bus_if.mem_we), 32'd0);
    check("rst_wr_oob", 32'(wr_oob), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset asserted while the buffer holds a write.
    cyc(1'b1, 0, 0, 1'b1, 5, 12'h123, acc);
    check("full_accept", 32'(acc), 32'd1);
    cyc(1'b1, 0, 0, 1'b0, 0, 12'h0, acc);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_ready", 32'(bus_if.wr_ready), 32'd1);
    check("async_rst_we", 32'(bus_if.mem_we), 32'd0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 0, 0, 1'b0, 0, 12'h0, acc);
    check("rst_discard", 32'(ram[5]), 32'(gold[5]));

    // Preloaded pixel 161 scanned at y=4, x=4..7.
    for (int i = 4; i < 8; i++) cyc(1'b1, i, 4, 1'b0, 0, 12'h0, acc);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 1'b0, 0, 12'h0, acc);

    // Writer held valid across a visible line, addresses 0..7.
    we_cnt = 0;
    begin
      int idx = 0;
      for (int i = 0; i < 32; i++) begin
        cyc(1'b1, i, 8, idx < 8, idx, 12'(idx * 291 + 7), acc);
        if (acc) idx++;
      end
      check("line_accepts", 32'(idx), 32'd8);
    end
    check("line_we_cnt", 32'(we_cnt), 32'd8);

    // 100 back-to-back writes during blanking.
    we_cnt = 0;
    addrs.delete();
    for (int i = 0; i < 100; i++) begin
      int a = $urandom_range(FB_WORDS - 1, 0);
      addrs.push_back(a);
      cyc(1'b0, 0, 0, 1'b1, a, 12'($urandom), acc);
      if (!acc) check("blank_stall", 32'(acc), 32'd1);
    end
    cyc(1'b0, 0, 0, 1'b0, 0, 12'h0, acc);
    cyc(1'b0, 0, 0, 1'b0, 0, 12'h0, acc);
    check("blank_we_cnt", 32'(we_cnt), 32'd100);
    for (int i = 0; i < 100; i += 7) begin
      check("blank_ram", 32'(ram[addrs[i]]), 32'(gold[addrs[i]]));
    end

    // Randomized scan segments with a concurrent random writer.
    cur_v = 1'b0;
    cur_a = 0;
    cur_d = 12'h0;
    for (int s = 0; s < 10; s++) begin
      ys  = $urandom_range(31, 0);
      xs  = 4 * $urandom_range(150, 0);
      len = 4 * $urandom_range(6, 2);
      for (int i = 0; i < len + 3; i++) begin
        if (!cur_v && ($urandom_range(1, 0) == 1)) begin
          cur_v = 1'b1;
          cur_a = $urandom_range(PRE_N - 1, 0);
          cur_d = 12'($urandom);
        end
        cyc(i < len, xs + (i < len ? i : 0), ys, cur_v, cur_a, cur_d, acc);
        if (acc) cur_v = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 1'b0, 0, 12'h0, acc);

    // Out-of-range write: accepted, never issued, sticky flag.
    we_cnt = 0;
    cyc(1'b0, 0, 0, 1'b1, FB_WORDS, 12'hFFF, acc);
    check("oob_ready", 32'(bus_if.wr_ready), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b0, 0, 12'h0, acc);
    check("oob_no_we", 32'(we_cnt), 32'd0);
    check("oob_sticky", 32'(wr_oob), 32'd1);
    do_reset();
    cyc(1'b0, 0, 0, 1'b0, 0, 12'h0, acc);
    check("oob_cleared", 32'(wr_oob), 32'd0);

    // Write to pixel (0,0) mid-group; visible from the next frame.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, i, 0, i == 2, 0, 12'h0F0, acc);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b0, 0, 12'h0, acc);
    for (int i = 0; i < 8; i++) cyc(1'b1, i, 0, 1'b0, 0, 12'h0, acc);
    for (int i = 0; i < 2; i++) cyc(1'b0, 0, 0, 1'b0, 0, 12'h0, acc);
    check("frame_ram0", 32'(ram[0]), 32'h0F0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
